param_multicycle_cpu: RTL
=========================

Name: param_multicycle_cpu

Overview:
- Parametrised successor to the 8-bit single-cycle processor: configurable data width, register count and program depth.
- Multi-cycle FETCH/EXEC core with a writable program memory, zero/carry flags, a conditional branch and HALT.
- A start/halt handshake lets a host load a program, run it and read results.
- Sits where the single-cycle processor sits under the Tiny Tapeout top.

Parameters:
DATA_W, 8, datapath and register width (>=4)
REG_AW, 2, register address bits; 2**REG_AW registers
IMEM_AW, 4, program memory address bits; 2**IMEM_AW words; must be <= 3*REG_AW
(derived, not overridable) IW = 4 + 3*REG_AW instruction width; default 10

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  synchronous active-low reset
start  in  1  run request; sampled only in HALTED
prog_we  in  1  program write strobe; honoured only in HALTED
prog_addr  in  IMEM_AW  program write address
prog_data  in  IW  program write word
dbg_raddr  in  REG_AW  debug register read address
dbg_rdata  out  DATA_W  combinational read of register dbg_raddr
pc  out  IMEM_AW  current program counter
busy  out  1  high in FETCH/EXEC
halted  out  1  high in HALTED
result  out  DATA_W  last value written to a register
result_valid  out  1  one-cycle pulse when a register write commits
zero  out  1  Z flag
carry  out  1  C flag (carry for ADD, borrow for SUB)

Behaviour:
- Reset (rst_n low at clk edge):
  - state=HALTED, pc=0, IR=0, all registers=0, result=0, result_valid=0, zero=0, carry=0.
  - Program memory is not cleared.
  - Reset mid-program aborts the program immediately; an in-flight EXEC does not commit.
- Instruction word fields:
  - op=[IW-1:IW-4], rd=next REG_AW bits, rs1=next REG_AW bits, rs2=low REG_AW bits.
  - imm = low 2*REG_AW bits, zero-extended.
  - tgt = low IMEM_AW bits of the low 3*REG_AW field.
- Opcodes:
  - 0 NOP
  - 1 ADD rd=rs1+rs2
  - 2 SUB rd=rs1-rs2
  - 3 AND
  - 4 OR
  - 5 XOR
  - 6 LDI rd=imm
  - 7 JMP pc=tgt
  - 8 BZ: if zero, pc=tgt, else pc+1
  - 9 HALT
  - 10-15 NOP
- Arithmetic:
  - All results are truncated to DATA_W.
  - ADD: C = carry out of bit DATA_W-1.
  - SUB: C=1 iff rs1<rs2 (unsigned).
  - AND/OR/XOR: C=0.
  - Z=(result==0) for opcodes 1-5 only; LDI, JMP, BZ, NOP and HALT leave the flags unchanged.
- FSM:
  - HALTED: start=1 -> FETCH with pc=0.
  - FETCH: IR<=imem[pc]; -> EXEC.
  - EXEC: commit the op; -> FETCH, except HALT -> HALTED with pc unchanged.
- Latency:
  - Two cycles per instruction.
  - With start sampled at edge S, instruction k commits at edge S+2k+2.
  - result_valid is high the cycle after a committing edge, for opcodes 1-6 only.
- pc update in EXEC:
  - pc+1, wrapping from 2**IMEM_AW-1 to 0, unless JMP, taken BZ, or HALT.
- Register reads in EXEC use pre-commit values; rd==rs1/rs2 is legal.
- Program load:
  - prog_we is written at the edge only in HALTED.
  - prog_we and start asserted in the same cycle: the write lands and the run starts; the first FETCH sees the new word.
  - prog_we and start are ignored while busy.
- dbg_rdata is combinational and reflects a write on the cycle after its commit edge.
- busy = !halted at all times.

Test Plan:
1. Reset then idle: halted=1, busy=0, pc=0, dbg_rdata=0 for all regs, zero=carry=0; start with no program held -> program of all-zero words loops forever (NOP wrap); pc wraps 15->0.
2. Load LDI r1,5; LDI r2,3; ADD r3,r1,r2; HALT; pulse start -> result_valid pulses with 5, 3, 8 at edges S+3, S+5, S+7 (high the cycle after commits at S+2, S+4, S+6); halted=1 at S+8; r3=0x08, Z=0, C=0.
3. After LDI r1,5; LDI r2,3: SUB r0,r2,r1 -> r0=0xFE, C=1, Z=0; then SUB r0,r1,r1 -> r0=0x00, Z=1, C=0.
4. Z=1, then BZ tgt=0xA taken -> pc=10; with Z=0, BZ falls through -> pc+1; JMP 2 -> pc=2 with flags unchanged.
5. Assert rst_n=0 during EXEC of ADD r3 -> r3 stays 0, halted=1 the next cycle; prog_we while busy -> imem unchanged (verified by rerunning the program).
6. DATA_W=16, REG_AW=3, IMEM_AW=5: LDI r7,63; ADD r6,r7,r7 -> r6=0x007E; program at addr 31 without HALT wraps to addr 0.

Source files
------------

// File: rtl/param_multicycle_cpu.sv
// -----------------------------------------------------------------------------
// param_multicycle_cpu
//
// Parametrised multi-cycle processor with a host-writable program memory.
// Each instruction takes two cycles: FETCH loads the instruction register from
// program memory, and EXEC commits the operation. A host loads a program while
// the core is HALTED, pulses start, and reads back results through the debug
// register port. HALT returns the core to HALTED with pc left on the HALT.
//
// Parameters
//   DATA_W   datapath / register width (>= 4)
//   REG_AW   register address bits, 2**REG_AW registers
//   IMEM_AW  program memory address bits, 2**IMEM_AW words (<= 3*REG_AW)
//   IW       derived instruction width, 4 + 3*REG_AW
//
// Instruction word: {op[3:0], rd, rs1, rs2}
//   imm = low 2*REG_AW bits (zero-extended), tgt = low IMEM_AW bits
//
// Ports
//   clk           system clock, rising edge
//   rst_n         synchronous active-low reset
//   start         run request, sampled only while halted
//   prog_we       program write strobe, honoured only while halted
//   prog_addr     program write address
//   prog_data     program write word
//   dbg_raddr     debug register read address
//   dbg_rdata     combinational read of register dbg_raddr
//   pc            current program counter
//   busy          high in FETCH/EXEC
//   halted        high in HALTED
//   result        last value written to a register
//   result_valid  one-cycle pulse after a register write commits
//   zero          Z flag
//   carry         C flag (carry for ADD, borrow for SUB)
// -----------------------------------------------------------------------------
module param_multicycle_cpu #(
  parameter  int DATA_W  = 8,
  parameter  int REG_AW  = 2,
  parameter  int IMEM_AW = 4,
  localparam int IW      = 4 + 3 * REG_AW
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               prog_we,
  input  logic [IMEM_AW-1:0] prog_addr,
  input  logic [IW-1:0]      prog_data,
  input  logic [REG_AW-1:0]  dbg_raddr,
  output logic [DATA_W-1:0]  dbg_rdata,
  output logic [IMEM_AW-1:0] pc,
  output logic               busy,
  output logic               halted,
  output logic [DATA_W-1:0]  result,
  output logic               result_valid,
  output logic               zero,
  output logic               carry
);

  localparam int NREGS  = 2 ** REG_AW;
  localparam int NWORDS = 2 ** IMEM_AW;

  typedef enum logic [1:0] {
    S_HALTED = 2'd0,
    S_FETCH  = 2'd1,
    S_EXEC   = 2'd2
  } state_e;

  typedef enum logic [3:0] {
    OP_NOP  = 4'd0,
    OP_ADD  = 4'd1,
    OP_SUB  = 4'd2,
    OP_AND  = 4'd3,
    OP_OR   = 4'd4,
    OP_XOR  = 4'd5,
    OP_LDI  = 4'd6,
    OP_JMP  = 4'd7,
    OP_BZ   = 4'd8,
    OP_HALT = 4'd9
  } opcode_e;

  state_e             state_q;
  logic [IMEM_AW-1:0] pc_q;
  logic [IW-1:0]      ir_q;
  logic [DATA_W-1:0]  regs_q [NREGS];
  logic [IW-1:0]      imem_q [NWORDS];
  logic [DATA_W-1:0]  result_q;
  logic               result_valid_q;
  logic               zero_q;
  logic               carry_q;

  // Instruction fields
  logic [3:0]        op;
  logic [REG_AW-1:0] rd;
  logic [REG_AW-1:0] rs1;
  logic [REG_AW-1:0] rs2;
  logic [DATA_W-1:0] imm;
  logic [DATA_W-1:0] opa;
  logic [DATA_W-1:0] opb;

  assign op  = ir_q[IW-1 -: 4];
  assign rd  = ir_q[3*REG_AW-1 -: REG_AW];
  assign rs1 = ir_q[2*REG_AW-1 -: REG_AW];
  assign rs2 = ir_q[REG_AW-1:0];
  assign imm = DATA_W'(ir_q[2*REG_AW-1:0]);
  // Operands are read from the pre-commit register file, so rd may alias rs1/rs2.
  assign opa = regs_q[rs1];
  assign opb = regs_q[rs2];

  // Execute-stage decode: what EXEC would commit for the current IR
  logic [DATA_W:0]    sum_ext;
  logic [DATA_W-1:0]  alu_d;
  logic               carry_d;
  logic               wr_en;
  logic               flags_we;
  logic               halt_op;
  logic [IMEM_AW-1:0] pc_d;

  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis would infer a latch.
  always_comb begin
    sum_ext  = '0;
    alu_d    = '0;
    carry_d  = 1'b0;
    wr_en    = 1'b0;
    flags_we = 1'b0;
    halt_op  = 1'b0;
    pc_d     = pc_q + IMEM_AW'(1);
    case (op)
      OP_ADD: begin
        sum_ext  = {1'b0, opa} + {1'b0, opb};
        alu_d    = sum_ext[DATA_W-1:0];
        carry_d  = sum_ext[DATA_W];
        wr_en    = 1'b1;
        flags_we = 1'b1;
      end
      OP_SUB: begin
        // The extra top bit of the widened difference is the unsigned borrow.
        sum_ext  = {1'b0, opa} - {1'b0, opb};
        alu_d    = sum_ext[DATA_W-1:0];
        carry_d  = sum_ext[DATA_W];
        wr_en    = 1'b1;
        flags_we = 1'b1;
      end
      OP_AND: begin
        alu_d    = opa & opb;
        wr_en    = 1'b1;
        flags_we = 1'b1;
      end
      OP_OR: begin
        alu_d    = opa | opb;
        wr_en    = 1'b1;
        flags_we = 1'b1;
      end
      OP_XOR: begin
        alu_d    = opa ^ opb;
        wr_en    = 1'b1;
        flags_we = 1'b1;
      end
      OP_LDI: begin
        alu_d = imm;
        wr_en = 1'b1;
      end
      OP_JMP: pc_d = ir_q[IMEM_AW-1:0];
      OP_BZ: begin
        if (zero_q) pc_d = ir_q[IMEM_AW-1:0];
      end
      OP_HALT: begin
        halt_op = 1'b1;
        pc_d    = pc_q;
      end
      default: ;
    endcase
  end

  // NOTE: program memory is deliberately left out of reset so a loaded
  // program survives a core reset; it has no reset branch at all.
  always_ff @(posedge clk) begin
    if (state_q == S_HALTED && prog_we) begin
      imem_q[prog_addr] <= prog_data;
    end
  end

  // NOTE: all state is updated with non-blocking assignments so every
  // register samples pre-edge values, matching the hardware it describes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= S_HALTED;
      pc_q           <= '0;
      ir_q           <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      zero_q         <= 1'b0;
      carry_q        <= 1'b0;
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      result_valid_q <= 1'b0;
      case (state_q)
        S_HALTED: begin
          if (start) begin
            state_q <= S_FETCH;
            pc_q    <= '0;
          end
        end
        S_FETCH: begin
          ir_q    <= imem_q[pc_q];
          state_q <= S_EXEC;
        end
        S_EXEC: begin
          if (wr_en) begin
            regs_q[rd]     <= alu_d;
            result_q       <= alu_d;
            result_valid_q <= 1'b1;
          end
          if (flags_we) begin
            zero_q  <= (alu_d == '0);
            carry_q <= carry_d;
          end
          pc_q    <= pc_d;
          state_q <= halt_op ? S_HALTED : S_FETCH;
        end
        default: state_q <= S_HALTED;
      endcase
    end
  end

  assign dbg_rdata    = regs_q[dbg_raddr];
  assign pc           = pc_q;
  assign halted       = (state_q == S_HALTED);
  assign busy         = !halted;
  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign zero         = zero_q;
  assign carry        = carry_q;

endmodule
